// File: rtl/ann_wbs_pkg.sv
// Shared address map, FSM states and region decode
// for the Wishbone slave front end of the accelerator.
package ann_wbs_pkg;

   localparam logic [31:0] ADDR_MASK  = 32'hFFFF_0000;
   localparam logic [31:0] CSR_BASE   = 32'h3000_0000;
   localparam logic [31:0] QUERY_BASE = 32'h3001_0000;
   localparam logic [31:0] LEAF_BASE  = 32'h3002_0000;
   localparam logic [31:0] BEST_BASE  = 32'h3003_0000;
   localparam logic [31:0] NODE_BASE  = 32'h3004_0000;

   localparam logic [15:0] OFF_MODE  = 16'h0000;
   localparam logic [15:0] OFF_DEBUG = 16'h0004;
   localparam logic [15:0] OFF_DONE  = 16'h0008;
   localparam logic [15:0] OFF_START = 16'h000C;
   localparam logic [15:0] OFF_BUSY  = 16'h0010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_ACK,
      ST_TURN
   } wbs_state_e;

   typedef enum logic [2:0] {
      RG_NONE,
      RG_CSR,
      RG_QUERY,
      RG_LEAF,
      RG_BEST,
      RG_NODE
   } region_e;

   function automatic region_e decode_region(input logic [31:0] adr);
      logic [31:0] r;
      r = adr & ADDR_MASK;
      case (r)
         CSR_BASE:   return RG_CSR;
         QUERY_BASE: return RG_QUERY;
         LEAF_BASE:  return RG_LEAF;
         BEST_BASE:  return RG_BEST;
         NODE_BASE:  return RG_NODE;
         default:    return RG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wbs_ctrl_decoder.sv
// Wishbone classic slave: CSR page, memory write windows,
// best-index readback and the fsm_start pulse.
module wbs_ctrl_decoder
   import ann_wbs_pkg::*;
#(
   parameter int DATA_WIDTH = 11,
   parameter int QUERY_AW   = 9,
   parameter int LEAF_AW    = 9,
   parameter int BEST_AW    = 9,
   parameter int NODE_AW    = 6
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic [31:0]             wbs_dat_o,
   output logic                    mode_o,
   output logic                    debug_o,
   output logic                    fsm_start_o,
   input  logic                    fsm_done_i,
   input  logic                    fsm_busy_i,
   output logic                    query_we_o,
   output logic [QUERY_AW-1:0]     query_addr_o,
   output logic [5*DATA_WIDTH-1:0] query_wdata_o,
   output logic                    leaf_we_o,
   output logic [LEAF_AW-1:0]      leaf_addr_o,
   output logic [63:0]             leaf_wdata_o,
   output logic                    node_we_o,
   output logic [NODE_AW-1:0]      node_addr_o,
   output logic [2*DATA_WIDTH-1:0] node_wdata_o,
   output logic                    best_re_o,
   output logic [BEST_AW-1:0]      best_addr_o,
   input  logic [DATA_WIDTH-1:0]   best_rdata_i
);

   wbs_state_e  state, state_nx;
   region_e     rgn;
   logic [15:0] off;
   logic        req, acc, wr, rd, half, mem_ok, csr_wr;
   logic        lo_ld, done_clr;
   logic [31:0] lo_hold, dat_q, csr_rd;
   logic [63:0] pair;
   logic        mode_q, debug_q, done_q;
   logic        unused_sel;

   assign unused_sel = ^wbs_sel_i;

   assign req    = wbs_cyc_i & wbs_stb_i;
   assign acc    = req & (state == ST_IDLE) & ~wb_rst_i;
   assign wr     = acc & wbs_we_i;
   assign rd     = acc & ~wbs_we_i;
   assign rgn    = decode_region(wbs_adr_i);
   assign off    = wbs_adr_i[15:0];
   assign half   = wbs_adr_i[2];
   assign mem_ok = ~fsm_busy_i;
   assign csr_wr = wr & (rgn == RG_CSR);
   assign pair   = {wbs_dat_i, lo_hold};

   assign query_addr_o  = wbs_adr_i[3 +: QUERY_AW];
   assign leaf_addr_o   = wbs_adr_i[3 +: LEAF_AW];
   assign best_addr_o   = wbs_adr_i[3 +: BEST_AW];
   assign node_addr_o   = wbs_adr_i[NODE_AW-1:0];
   assign query_wdata_o = pair[5*DATA_WIDTH-1:0];
   assign leaf_wdata_o  = pair;
   assign node_wdata_o  = wbs_dat_i[2*DATA_WIDTH-1:0];

   assign mode_o  = mode_q;
   assign debug_o = debug_q;

   // State register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ST_IDLE;
      else          state <= state_nx;
   end

   // Next state: best reads take an extra wait cycle for the SRAM
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (acc) state_nx = best_re_o ? ST_RD_WAIT : ST_ACK;
         ST_RD_WAIT: state_nx = ST_ACK;
         ST_ACK:     state_nx = ST_TURN;
         ST_TURN:    state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Outputs: strobes only in the accept cycle, gated while busy
   always_comb begin
      wbs_ack_o   = (state == ST_ACK);
      wbs_dat_o   = wbs_ack_o ? dat_q : 32'h0;
      query_we_o  = wr & mem_ok & (rgn == RG_QUERY) & half;
      leaf_we_o   = wr & mem_ok & (rgn == RG_LEAF) & half;
      node_we_o   = wr & mem_ok & (rgn == RG_NODE);
      best_re_o   = rd & mem_ok & (rgn == RG_BEST);
      lo_ld       = wr & mem_ok & ~half &
                    ((rgn == RG_QUERY) | (rgn == RG_LEAF));
      fsm_start_o = csr_wr & (off == OFF_START) & ~fsm_busy_i;
      done_clr    = (csr_wr & (off == OFF_DONE)) | fsm_start_o;
   end

   // CSR readback mux
   always_comb begin
      csr_rd = 32'h0;
      if (rgn == RG_CSR) begin
         case (off)
            OFF_MODE:  csr_rd[0] = mode_q;
            OFF_DEBUG: csr_rd[0] = debug_q;
            OFF_DONE:  csr_rd[0] = done_q;
            OFF_BUSY:  csr_rd[0] = fsm_busy_i;
            default:   csr_rd[0] = 1'b0;
         endcase
      end
   end

   // Control bits; a done pulse beats a coincident clear
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         mode_q  <= 1'b0;
         debug_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (csr_wr && off == OFF_MODE)  mode_q  <= wbs_dat_i[0];
         if (csr_wr && off == OFF_DEBUG) debug_q <= wbs_dat_i[0];
         done_q <= fsm_done_i | (done_q & ~done_clr);
      end
   end

   // Lower-half holding register and read data capture
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         lo_hold <= 32'h0;
         dat_q   <= 32'h0;
      end else begin
         if (lo_ld) lo_hold <= wbs_dat_i;
         if (acc)
            dat_q <= wr ? 32'h0 : csr_rd;
         else if (state == ST_RD_WAIT)
            dat_q <= {{(32-DATA_WIDTH){1'b0}}, best_rdata_i};
      end
   end

endmodule
